// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one pipelined sprite ROM read port between the
// player-1 and player-2 pixel fetch units; returned words are tagged per requester.
module sprite_rom_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 12,
  parameter int ROM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  output logic              gnt2,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid1,
  output logic              rdata_valid2
);

  // Handshake: reqN is held with a stable addrN until gntN is seen high in the
  // same cycle; that cycle is the transfer, and the requester may change or
  // drop the request from the next cycle on. rdata_validN is a one-cycle
  // strobe with no back-pressure.

  logic                 last_is_p2;
  logic                 grant;
  logic [ROM_LATENCY:0] tag_v;
  logic [ROM_LATENCY:0] tag_p2;

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (!reset && enable) begin
      if (req1 && req2) begin
        gnt1 = last_is_p2;
        gnt2 = !last_is_p2;
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
  end

  assign grant = gnt1 | gnt2;

  // Tag stage ROM_LATENCY lines up with rom_data for the read it describes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_is_p2   <= 1'b1;
      rom_rd       <= 1'b0;
      rom_addr     <= '0;
      tag_v        <= '0;
      tag_p2       <= '0;
      rdata        <= '0;
      rdata_valid1 <= 1'b0;
      rdata_valid2 <= 1'b0;
    end else begin
      if (frame_start)
        last_is_p2 <= 1'b1;
      else if (grant)
        last_is_p2 <= gnt2;

      rom_rd <= grant;
      if (grant)
        rom_addr <= gnt1 ? addr1 : addr2;

      tag_v  <= {tag_v[ROM_LATENCY-1:0], grant};
      tag_p2 <= {tag_p2[ROM_LATENCY-1:0], gnt2};

      rdata_valid1 <= tag_v[ROM_LATENCY] & ~tag_p2[ROM_LATENCY];
      rdata_valid2 <= tag_v[ROM_LATENCY] & tag_p2[ROM_LATENCY];
      if (tag_v[ROM_LATENCY])
        rdata <= rom_data;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed scenarios then random traffic, all
// checked every cycle against a cycle-indexed reference model of the arbiter.
module tb_sprite_rom_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 12;
  localparam int L      = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              frame_start = 1'b0;
  logic              req1 = 1'b0, req2 = 1'b0;
  logic [ADDR_W-1:0] addr1 = '0, addr2 = '0;
  logic              gnt1, gnt2, rom_rd, rdata_valid1, rdata_valid2;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  int                last_id = 2;
  int                prev_g = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_rdata = '0;
  int                sched_id[int];
  logic [DATA_W-1:0] sched_data[int];
  logic [ADDR_W-1:0] hist[L];

  sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .req2(req2), .addr2(addr2), .gnt2(gnt2),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rdata(rdata), .rdata_valid1(rdata_valid1), .rdata_valid2(rdata_valid2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] h;
    h = (a * 16'd37) ^ (a >> 5) ^ 16'h0A5C;
    return h[DATA_W-1:0];
  endfunction

  // ROM behaviour: data for the address presented ROM_LATENCY cycles earlier.
  always @(posedge clock) begin
    hist[0] <= rom_addr;
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end
  assign rom_data = rom_f(hist[L-1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_id = 2;
    prev_g = 0;
    exp_addr = '0;
    exp_rdata = '0;
    sched_id.delete();
    sched_data.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_gnt2"}, gnt2, 0);
    chk({tag, "_rom_rd"}, rom_rd, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_valid1"}, rdata_valid1, 0);
    chk({tag, "_valid2"}, rdata_valid2, 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    req1 = 0; req2 = 0; frame_start = 0;
    #1 chk_all_zero("reset_a");
    model_reset();
    @(posedge clock);
    #1 chk_all_zero("reset_b");
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, then check every output against the model.
  task automatic step(input logic r1, input logic [ADDR_W-1:0] a1,
                      input logic r2, input logic [ADDR_W-1:0] a2,
                      input logic en, input logic fs);
    int g;
    @(posedge clock);
    #1;
    req1 = r1; addr1 = a1; req2 = r2; addr2 = a2; enable = en; frame_start = fs;
    @(negedge clock);
    if (!en)             g = 0;
    else if (r1 && r2)   g = (last_id == 2) ? 1 : 2;
    else if (r1)         g = 1;
    else if (r2)         g = 2;
    else                 g = 0;
    chk("gnt1", gnt1, g == 1);
    chk("gnt2", gnt2, g == 2);
    chk("rom_rd", rom_rd, prev_g != 0);
    chk("rom_addr", rom_addr, exp_addr);
    if (sched_id.exists(cyc)) exp_rdata = sched_data[cyc];
    chk("valid1", rdata_valid1, sched_id.exists(cyc) && sched_id[cyc] == 1);
    chk("valid2", rdata_valid2, sched_id.exists(cyc) && sched_id[cyc] == 2);
    chk("rdata", rdata, exp_rdata);
    if (g != 0) begin
      exp_addr = (g == 1) ? a1 : a2;
      sched_id[cyc + L + 2] = g;
      sched_data[cyc + L + 2] = rom_f(exp_addr);
    end
    prev_g = g;
    if (fs) last_id = 2;
    else if (g != 0) last_id = g;
  endtask

  initial begin
    do_reset();
    // Single requester
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 16'h0010, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    // Contention from reset: grants alternate starting with player 1
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 16'h0100 + 16'(i), 1, 16'h0200 + 16'(i), 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    // Frame reseed: grant to 1 with frame_start, then both -> player 1 again
    step(1, 16'h0300, 0, 0, 1, 1);
    step(1, 16'h0301, 1, 16'h0401, 1, 0);
    // Same without frame_start -> player 2
    step(1, 16'h0302, 0, 0, 1, 0);
    step(1, 16'h0303, 1, 16'h0403, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // Enable gating with both held
    step(1, 16'h0500, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h0501, 1, 16'h0601, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 16'h0501, 1, 16'h0601, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    // Reset mid-flight
    step(1, 16'h0700, 0, 0, 1, 0);
    step(0, 0, 1, 16'h0800, 1, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 16'h0900, 1, 16'h0A00, 1, 0);
    step(1, 16'h0901, 1, 16'h0A01, 1, 0);
    // Idle: registered outputs hold
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, 0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single sprite ROM read port between the player-1 and player-2 pixel fetch units inside the PPU.
- The fetch units consume the 32-bit player words from the game-state block.
- Arbitration is round-robin with priority re-seeded to player 1 at every frame start.
- Fixed-latency pipelined reads; each returned word is tagged back to its requester.

Parameters:
ADDR_W, 16, sprite ROM word address width
DATA_W, 12, sprite ROM data width (pixel colour word)
ROM_LATENCY, 2, clocks from rom_rd/rom_addr registered to rom_data valid (must be >= 1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = grants allowed; 0 = no new grants, in-flight reads complete
frame_start  input  1  single-cycle pulse at start of each video frame
req1  input  1  player-1 fetch request, held until gnt1
addr1  input  ADDR_W  player-1 ROM address, stable while req1 high
gnt1  output  1  player-1 request accepted this cycle
req2  input  1  player-2 fetch request, held until gnt2
addr2  input  ADDR_W  player-2 ROM address, stable while req2 high
gnt2  output  1  player-2 request accepted this cycle
rom_rd  output  1  ROM read strobe (registered)
rom_addr  output  ADDR_W  ROM read address (registered)
rom_data  input  DATA_W  ROM read data, valid ROM_LATENCY cycles after rom_rd
rdata  output  DATA_W  returned data (registered, shared by both requesters)
rdata_valid1  output  1  rdata belongs to player 1 this cycle
rdata_valid2  output  1  rdata belongs to player 2 this cycle

Behaviour:
- Reset values:
  - gnt1, gnt2, rom_rd, rdata_valid1, rdata_valid2 = 0; rom_addr, rdata = 0.
  - Pointer last_grant = 2, so player 1 wins first.
  - Tag pipeline cleared.
- Grant (combinational in cycle t, at most one of gnt1/gnt2 high):
  - enable=0 -> none.
  - Only req1 -> gnt1; only req2 -> gnt2.
  - Both -> grant the requester that was not last_grant.
- Pointer: updates on the clock edge after any grant to the granted id; unchanged on cycles without a grant.
- frame_start:
  - The same-cycle grant uses the old pointer.
  - Pointer is then forced to 2 regardless of that grant; frame_start wins over the grant update.
- Read issue, cycle t+1:
  - rom_rd=1, rom_addr = granted address.
  - With no grant: rom_rd=0 and rom_addr holds its previous value.
- Tag pipeline:
  - Shift register of depth ROM_LATENCY+1 carrying {valid, id}.
  - Entry launched with the grant; emerges aligned with rom_data.
- Return, cycle t+2+ROM_LATENCY:
  - rdata registered from rom_data.
  - Exactly the tagged rdata_validN high for one cycle.
  - When no valid tag, rdata holds its previous value.
- Latency: gnt to rdata_validN = ROM_LATENCY+2 cycles.
  - Throughput is one read per cycle; back-to-back grants produce back-to-back valids in grant order.
- Fairness: with both requesting continuously, grants alternate every cycle. Maximum wait for a held request is 1 cycle while enable=1.
- Requesters may change addr or deassert req in the cycle after gnt. The arbiter does not re-check req after granting.
- enable falling: in-flight reads still return their valids; no new grants.
- req dropped without grant: no effect, no read issued.
- Reset mid-operation: all in-flight reads discarded; no rdata_valid after reset release until new grants mature.

Test Plan:
- Single requester: ROM_LATENCY=2, req1=1, addr1=0x0010 at cycle 5 -> gnt1 at cycle 5; rom_rd=1, rom_addr=0x0010 at cycle 6; rdata_valid1=1 with rdata=ROM[0x0010] at cycle 9; rdata_valid2 never high.
- Contention: req1 and req2 held high for 6 cycles from reset release -> grants 1,2,1,2,1,2; valids return in the same order, each 4 cycles after its grant, with matching data.
- Frame reseed:
  - Grant to 1 at cycle 10, frame_start pulses at cycle 10, both request at cycle 11 -> gnt1 at cycle 11 (pointer forced to 2).
  - Without frame_start, the same sequence -> gnt2 at cycle 11.
- Enable gating: grant at cycle 20, enable=0 at cycles 21-25 with both requesting -> no gnt during 21-25; valid for the cycle-20 grant still appears at cycle 24; grants resume at cycle 26 after enable=1.
- Reset mid-flight: grants at cycles 30 and 31, reset pulsed at cycle 32 -> no rdata_valid at cycles 34/35; all outputs 0 during reset; first grant after release goes to player 1 when both request.
- Idle behaviour: no requests for 50 cycles -> rom_rd=0 throughout; rom_addr and rdata keep last values; no valids.
